// File: rtl/onehot_codec_pipe.sv
// Registered binary<->one-hot codec with valid/ready flow control.
// One output register stage; illegal codes are flagged and counted.
module onehot_codec_pipe #(
    parameter int BIN_W = 4,
    parameter int OH_W  = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [OH_W-1:0]  in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [OH_W-1:0]  out_data_o,
    output logic             out_err_o,
    output logic [CNT_W-1:0] err_cnt_o
);

    logic [BIN_W-1:0] idx;
    logic [BIN_W-1:0] low_idx;
    logic [OH_W-1:0]  enc_data;
    logic [OH_W-1:0]  next_data;
    logic             enc_err;
    logic             dec_err;
    logic             next_err;
    logic             accept;

    assign in_ready_o = !out_valid_o || out_ready_i;
    assign accept     = in_valid_i && in_ready_o;

    always_comb begin
        idx      = in_data_i[BIN_W-1:0];
        enc_data = '0;
        enc_err  = 1'b1;
        if (32'(idx) < OH_W) begin
            enc_data = OH_W'(1) << idx;
            enc_err  = 1'b0;
        end
    end

    // Scan downward so the lowest set bit wins on multi-hot input.
    always_comb begin
        low_idx = '0;
        for (int i = OH_W - 1; i >= 0; i--) begin
            if (in_data_i[i]) begin
                low_idx = BIN_W'(i);
            end
        end
        dec_err = (in_data_i == '0)
               || (|(in_data_i & (in_data_i - OH_W'(1))));
    end

    always_comb begin
        next_data = enc_data;
        next_err  = enc_err;
        if (mode_i) begin
            next_data = OH_W'(low_idx);
            next_err  = dec_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_err_o   <= 1'b0;
            err_cnt_o   <= '0;
        end else begin
            out_valid_o <= accept || (out_valid_o && !out_ready_i);
            if (accept) begin
                out_data_o <= next_data;
                out_err_o  <= next_err;
                if (next_err && (err_cnt_o != '1)) begin
                    err_cnt_o <= err_cnt_o + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_onehot_codec_pipe.sv
// Directed bench for onehot_codec_pipe: default, OH_W=10 and CNT_W=2
// instances share one stimulus stream; each phase checks one instance.
module tb_onehot_codec_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_ready;

    logic        rdy0, val0, err0;
    logic [15:0] dat0;
    logic [7:0]  cnt0;
    logic        rdy1, val1, err1;
    logic [9:0]  dat1;
    logic [7:0]  cnt1;
    logic        rdy2, val2, err2;
    logic [15:0] dat2;
    logic [1:0]  cnt2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    onehot_codec_pipe u0 (
        .clk(clk), .rst(rst), .mode_i(mode),
        .in_valid_i(in_valid), .in_ready_o(rdy0), .in_data_i(in_data),
        .out_valid_o(val0), .out_ready_i(out_ready), .out_data_o(dat0),
        .out_err_o(err0), .err_cnt_o(cnt0)
    );

    onehot_codec_pipe #(.OH_W(10)) u1 (
        .clk(clk), .rst(rst), .mode_i(mode),
        .in_valid_i(in_valid), .in_ready_o(rdy1), .in_data_i(in_data[9:0]),
        .out_valid_o(val1), .out_ready_i(out_ready), .out_data_o(dat1),
        .out_err_o(err1), .err_cnt_o(cnt1)
    );

    onehot_codec_pipe #(.CNT_W(2)) u2 (
        .clk(clk), .rst(rst), .mode_i(mode),
        .in_valid_i(in_valid), .in_ready_o(rdy2), .in_data_i(in_data),
        .out_valid_o(val2), .out_ready_i(out_ready), .out_data_o(dat2),
        .out_err_o(err2), .err_cnt_o(cnt2)
    );

    typedef struct {
        logic        mode;
        logic [15:0] data;
        logic [15:0] exp_data;
        logic        exp_err;
        logic [7:0]  exp_cnt;
    } vec_t;

    vec_t vecs[22];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        mode = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b1;

        for (int i = 0; i < 16; i++) begin
            vecs[i] = '{1'b0, 16'(i), 16'h0001 << i, 1'b0, 8'd0};
        end
        vecs[16] = '{1'b1, 16'h0040, 16'd6,  1'b0, 8'd0};
        vecs[17] = '{1'b1, 16'h8000, 16'd15, 1'b0, 8'd0};
        vecs[18] = '{1'b1, 16'h0000, 16'd0,  1'b1, 8'd1};
        vecs[19] = '{1'b1, 16'h0028, 16'd3,  1'b1, 8'd2};
        vecs[20] = '{1'b1, 16'h0001, 16'd0,  1'b0, 8'd2};
        vecs[21] = '{1'b0, 16'hFFF3, 16'h0008, 1'b0, 8'd2};

        // reset state
        do_reset();
        check("rst_valid", 32'(val0), 32'd0);
        check("rst_data",  32'(dat0), 32'd0);
        check("rst_err",   32'(err0), 32'd0);
        check("rst_cnt",   32'(cnt0), 32'd0);
        check("rst_ready", 32'(rdy0), 32'd1);

        // back-to-back table, no backpressure
        for (int i = 0; i <= 22; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check($sformatf("v%0d_valid", i - 1), 32'(val0), 32'd1);
                check($sformatf("v%0d_data", i - 1), 32'(dat0),
                      32'(vecs[i-1].exp_data));
                check($sformatf("v%0d_err", i - 1), 32'(err0),
                      32'(vecs[i-1].exp_err));
                check($sformatf("v%0d_cnt", i - 1), 32'(cnt0),
                      32'(vecs[i-1].exp_cnt));
                check($sformatf("v%0d_ready", i - 1), 32'(rdy0), 32'd1);
            end
            if (i < 22) begin
                mode = vecs[i].mode;
                in_data = vecs[i].data;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        check("drain_valid", 32'(val0), 32'd0);
        check("drain_data",  32'(dat0), 32'h0008);

        // decode under backpressure; second beat must wait
        do_reset();
        mode = 1'b1;
        in_data = 16'h0040;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        in_data = 16'h8000;
        for (int c = 0; c < 3; c++) begin
            check("bp_valid", 32'(val0), 32'd1);
            check("bp_data",  32'(dat0), 32'd6);
            check("bp_ready", 32'(rdy0), 32'd0);
            @(negedge clk);
        end
        check("bp_hold_data", 32'(dat0), 32'd6);
        out_ready = 1'b1;
        #1;
        check("bp_ready_comb", 32'(rdy0), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_next_valid", 32'(val0), 32'd1);
        check("bp_next_data",  32'(dat0), 32'd15);
        check("bp_cnt",        32'(cnt0), 32'd0);
        @(negedge clk);
        check("bp_drain_valid", 32'(val0), 32'd0);
        check("bp_drain_data",  32'(dat0), 32'd15);

        // non-power-of-two width
        do_reset();
        mode = 1'b0;
        in_data = 16'd9;
        in_valid = 1'b1;
        @(negedge clk);
        check("np2_9_data", 32'(dat1), 32'h200);
        check("np2_9_err",  32'(err1), 32'd0);
        in_data = 16'd12;
        @(negedge clk);
        in_valid = 1'b0;
        check("np2_12_valid", 32'(val1), 32'd1);
        check("np2_12_data",  32'(dat1), 32'h000);
        check("np2_12_err",   32'(err1), 32'd1);
        check("np2_12_cnt",   32'(cnt1), 32'd1);

        // saturating counter
        do_reset();
        mode = 1'b1;
        in_data = 16'h0000;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 4) in_valid = 1'b0;
            check($sformatf("sat%0d_err", k), 32'(err2), 32'd1);
            check($sformatf("sat%0d_cnt", k), 32'(cnt2),
                  (k < 3) ? 32'(k + 1) : 32'd3);
        end
        @(negedge clk);
        check("sat_hold_cnt", 32'(cnt2), 32'd3);

        // reset while a result is stalled
        do_reset();
        mode = 1'b1;
        in_data = 16'h0000;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        check("ms_pre_valid", 32'(val0), 32'd1);
        check("ms_pre_cnt",   32'(cnt0), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("ms_valid", 32'(val0), 32'd0);
        check("ms_data",  32'(dat0), 32'd0);
        check("ms_err",   32'(err0), 32'd0);
        check("ms_cnt",   32'(cnt0), 32'd0);
        check("ms_ready", 32'(rdy0), 32'd1);
        @(negedge clk);
        check("ms_no_replay", 32'(val0), 32'd0);
        out_ready = 1'b1;
        in_data = 16'h0002;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("ms_new_valid", 32'(val0), 32'd1);
        check("ms_new_data",  32'(dat0), 32'd1);
        check("ms_new_err",   32'(err0), 32'd0);
        @(negedge clk);
        check("ms_end_valid", 32'(val0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
